// File: rtl/mc_bus_if_if.sv
// mc_bus_if_if: raw MCU memory-controller bus pins (active-low strobes, address, data)
// master drives the pins (MCU side / testbench), slave samples them (mc_bus_if)
interface mc_bus_if_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADD_WIDTH = 6
);
  logic mc_ce;
  logic mc_we;
  logic mc_oe;
  logic [ADD_WIDTH-1:0] mc_add;
  logic [DATA_WIDTH-1:0] mc_din;
  modport master (output mc_ce, mc_we, mc_oe, mc_add, mc_din);
  modport slave (input mc_ce, mc_we, mc_oe, mc_add, mc_din);
endinterface

// File: rtl/mc_bus_if.sv
// mc_bus_if: memory-controller bus front end turning raw strobes into single-clock write/read events
// clock, reset        : system clock, synchronous active-high reset
// bus (slave)         : raw mc_ce/mc_we/mc_oe (active low, async), mc_add, mc_din
// wr_stb/wr_add/wr_data : one pulse per completed write with latched address and data
// rd_start/rd_done/rd_add : pulses at read entry and read end, latched read address
// busy, err_conflict, glitch_cnt : FSM active, sticky WE+OE conflict, saturating aborted-write count
// timeout             : sticky cycle-too-long flag, present only with MC_BUS_TIMEOUT_EN defined
module mc_bus_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADD_WIDTH = 6,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  mc_bus_if_if.slave            bus,
  output logic                  wr_stb,
  output logic [ADD_WIDTH-1:0]  wr_add,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_start,
  output logic                  rd_done,
  output logic [ADD_WIDTH-1:0]  rd_add,
  output logic                  busy,
  output logic                  err_conflict,
`ifdef MC_BUS_TIMEOUT_EN
  output logic                  timeout,
`endif
  output logic [7:0]            glitch_cnt
);
  typedef enum logic [2:0] {IDLE, WR, WR_HELD, RD, CONFLICT} state_t;
  state_t state, state_n;
  logic [1:0] ce_q, we_q, oe_q, warm;
  logic ce_s, we_s, oe_s, armed, active, conflict, tmo;
  logic [3:0] settle, settle_n;
  logic wr_stb_n, rd_start_n, rd_done_n, lat_wr, lat_rd, glitch;
  assign ce_s = ce_q[1];
  assign we_s = we_q[1];
  assign oe_s = oe_q[1];
  assign active = state inside {WR, WR_HELD, RD};
  // IDLE only reacts once armed, so a cycle caught mid-flight by reset is ignored until the bus idles
  assign conflict = !we_s && !oe_s && (state == IDLE ? armed && !ce_s : active);
`ifdef MC_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  assign tmo = active && tcnt == TW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_n = state;
    settle_n = settle;
    wr_stb_n = 1'b0;
    rd_start_n = 1'b0;
    rd_done_n = 1'b0;
    lat_wr = 1'b0;
    lat_rd = 1'b0;
    glitch = 1'b0;
    if (tmo || conflict)
      state_n = CONFLICT;
    else
      case (state)
        IDLE: if (armed && !ce_s) begin
          if (!we_s) begin
            state_n = WR;
            settle_n = '0;
          end else if (!oe_s) begin
            state_n = RD;
            lat_rd = 1'b1;
            rd_start_n = 1'b1;
          end
        end
        WR: if (we_s || ce_s) begin
          state_n = IDLE;
          glitch = 1'b1;
        end else begin
          settle_n = settle + 4'd1;
          if (settle_n == 4'(SETTLE_CYCLES)) begin
            lat_wr = 1'b1;
            state_n = WR_HELD;
          end
        end
        WR_HELD: if (we_s || ce_s) begin
          state_n = IDLE;
          wr_stb_n = 1'b1;
        end
        RD: if (oe_s || ce_s) begin
          state_n = IDLE;
          rd_done_n = 1'b1;
        end
        CONFLICT: if (ce_s && we_s && oe_s) state_n = IDLE;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      ce_q <= '1;
      we_q <= '1;
      oe_q <= '1;
      warm <= '0;
      armed <= 1'b0;
      state <= IDLE;
      settle <= '0;
      wr_stb <= 1'b0;
      wr_add <= '0;
      wr_data <= '0;
      rd_start <= 1'b0;
      rd_done <= 1'b0;
      rd_add <= '0;
      busy <= 1'b0;
      err_conflict <= 1'b0;
      glitch_cnt <= '0;
`ifdef MC_BUS_TIMEOUT_EN
      tcnt <= '0;
      timeout <= 1'b0;
`endif
    end else begin
      ce_q <= {ce_q[0], bus.mc_ce};
      we_q <= {we_q[0], bus.mc_we};
      oe_q <= {oe_q[0], bus.mc_oe};
      // synced values are only genuine pad samples two clocks after reset
      warm <= {warm[0], 1'b1};
      armed <= armed || (warm[1] && ce_s && we_s && oe_s);
      state <= state_n;
      settle <= settle_n;
      wr_stb <= wr_stb_n;
      rd_start <= rd_start_n;
      rd_done <= rd_done_n;
      busy <= state_n != IDLE;
      if (lat_wr) begin
        wr_add <= bus.mc_add;
        wr_data <= bus.mc_din;
      end
      if (lat_rd) rd_add <= bus.mc_add;
      if (conflict) err_conflict <= 1'b1;
      if (glitch && glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
`ifdef MC_BUS_TIMEOUT_EN
      tcnt <= active ? tcnt + 1'b1 : '0;
      if (tmo) timeout <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_mc_bus_if.sv
// tb_mc_bus_if: directed self-checking bench for mc_bus_if
module tb_mc_bus_if;
  localparam int DW = 16;
  localparam int AW = 6;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  mc_bus_if_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) bus ();
  logic wr_stb, rd_start, rd_done, busy, err_conflict;
  logic [AW-1:0] wr_add, rd_add;
  logic [DW-1:0] wr_data;
  logic [7:0] glitch_cnt;
`ifdef MC_BUS_TIMEOUT_EN
  logic timeout;
`endif
  mc_bus_if #(
    .DATA_WIDTH(DW),
    .ADD_WIDTH(AW),
`ifdef MC_BUS_TIMEOUT_EN
    .TIMEOUT_CYCLES(10),
`endif
    .SETTLE_CYCLES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .wr_stb(wr_stb),
    .wr_add(wr_add),
    .wr_data(wr_data),
    .rd_start(rd_start),
    .rd_done(rd_done),
    .rd_add(rd_add),
    .busy(busy),
    .err_conflict(err_conflict),
`ifdef MC_BUS_TIMEOUT_EN
    .timeout(timeout),
`endif
    .glitch_cnt(glitch_cnt)
  );
  int cyc = 0, n_wr = 0, n_rs = 0, n_rd = 0, overlap = 0;
  int wr_cyc = 0, rs_cyc = 0, rd_cyc = 0;
  logic prev_wr = 1'b0, busy_after = 1'b1;
  logic [AW-1:0] m_wr_add = '0, m_rd_add = '0;
  logic [DW-1:0] m_wr_data = '0;
  always @(posedge clock) begin
    #1;
    cyc++;
    if (prev_wr) busy_after = busy;
    prev_wr = wr_stb;
    if (wr_stb) begin
      n_wr++;
      wr_cyc = cyc;
      m_wr_add = wr_add;
      m_wr_data = wr_data;
    end
    if (rd_start) begin
      n_rs++;
      rs_cyc = cyc;
      m_rd_add = rd_add;
    end
    if (rd_done) begin
      n_rd++;
      rd_cyc = cyc;
    end
    if (rd_start && rd_done) overlap++;
  end
  int n_chk = 0, n_pass = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic pins(logic ce, logic we, logic oe);
    bus.mc_ce = ce;
    bus.mc_we = we;
    bus.mc_oe = oe;
  endtask
  task automatic do_write(logic [AW-1:0] a, logic [DW-1:0] d, string tag);
    int b, rise;
    b = n_wr;
    bus.mc_add = a;
    bus.mc_din = d;
    pins(0, 0, 1);
    tick(6);
    pins(1, 1, 1);
    bus.mc_din = '0;
    bus.mc_add = '0;
    rise = cyc;
    tick(6);
    check({tag, "_count"}, n_wr - b, 1);
    check({tag, "_lat"}, wr_cyc - rise, 3);
    check({tag, "_add"}, m_wr_add, a);
    check({tag, "_data"}, m_wr_data, d);
    check({tag, "_hold"}, {wr_add, wr_data}, {a, d});
  endtask
  int b_wr, b_rs, b_rd, rise;
  initial begin
    pins(1, 1, 1);
    bus.mc_add = '0;
    bus.mc_din = '0;
    tick(3);
    check("rst_strobes", {wr_stb, rd_start, rd_done, busy, err_conflict}, 0);
    check("rst_regs", {wr_add, wr_data, rd_add, glitch_cnt}, 0);
    reset = 1'b0;
    tick(4);
    do_write(6'h19, 16'hA55A, "wr1");
    check("wr1_busy_after", busy_after, 0);
    b_wr = n_wr;
    for (int i = 0; i < 254; i++) begin
      pins(0, 0, 1);
      tick(1);
      pins(1, 1, 1);
      tick(3);
      if (i == 0) check("glitch_first", glitch_cnt, 1);
    end
    check("glitch_254", glitch_cnt, 254);
    for (int i = 0; i < 46; i++) begin
      pins(0, 0, 1);
      tick(1);
      pins(1, 1, 1);
      tick(3);
    end
    check("glitch_sat", glitch_cnt, 255);
    check("glitch_no_wr", n_wr - b_wr, 0);
    b_rs = n_rs;
    b_rd = n_rd;
    bus.mc_add = 6'h15;
    pins(0, 1, 0);
    tick(5);
    pins(1, 1, 1);
    bus.mc_add = 6'h3F;
    rise = cyc;
    tick(6);
    check("rd1_pairs", {n_rs - b_rs, n_rd - b_rd}, {32'd1, 32'd1});
    check("rd1_add", m_rd_add, 6'h15);
    check("rd1_done_lat", rd_cyc - rise, 3);
    check("rd1_hold", rd_add, 6'h15);
    bus.mc_add = 6'h00;
    pins(0, 1, 0);
    tick(5);
    pins(1, 1, 1);
    bus.mc_add = 6'h2A;
    tick(6);
    check("rd0_pairs", {n_rs - b_rs, n_rd - b_rd}, {32'd2, 32'd2});
    check("rd0_add", m_rd_add, 6'h00);
    check("rd0_order", rd_cyc > rs_cyc, 1);
    bus.mc_add = 6'h0A;
    pins(0, 1, 0);
    tick(3);
    bus.mc_oe = 1'b1;
    tick(1);
    bus.mc_add = 6'h0B;
    bus.mc_oe = 1'b0;
    tick(3);
    pins(1, 1, 1);
    tick(6);
    check("b2b_pairs", {n_rs - b_rs, n_rd - b_rd}, {32'd4, 32'd4});
    check("b2b_add", rd_add, 6'h0B);
    pins(0, 1, 0);
    tick(1);
    pins(1, 1, 1);
    tick(6);
    check("rd_short_pairs", {n_rs - b_rs, n_rd - b_rd}, {32'd5, 32'd5});
    check("rd_short_gap", rd_cyc - rs_cyc, 1);
    check("rd_overlap", overlap, 0);
    b_wr = n_wr;
    b_rs = n_rs;
    b_rd = n_rd;
    bus.mc_add = 6'h05;
    bus.mc_din = 16'h1234;
    pins(0, 0, 0);
    tick(4);
    check("cf_flag", err_conflict, 1);
    pins(1, 1, 1);
    tick(5);
    check("cf_no_strobes", {n_wr - b_wr, n_rs - b_rs, n_rd - b_rd}, 0);
    check("cf_idle", busy, 0);
    pins(0, 1, 0);
    tick(4);
    bus.mc_we = 1'b0;
    tick(3);
    pins(1, 1, 1);
    tick(6);
    check("cf_rd_pairs", {n_rs - b_rs, n_rd - b_rd}, {32'd1, 32'd0});
    do_write(6'h2C, 16'h5AA5, "wr_cf");
    check("cf_sticky", err_conflict, 1);
    b_wr = n_wr;
    bus.mc_add = 6'h33;
    bus.mc_din = 16'hBEEF;
    pins(0, 0, 1);
    tick(6);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid_rst_strobes", {wr_stb, rd_start, rd_done, busy, err_conflict}, 0);
    check("mid_rst_regs", {wr_add, wr_data, rd_add, glitch_cnt}, 0);
    tick(4);
    check("mid_rst_ignored", busy, 0);
    pins(1, 1, 1);
    tick(6);
    check("mid_rst_no_wr", n_wr - b_wr, 0);
    do_write(6'h07, 16'h0F0F, "wr_post");
`ifdef MC_BUS_TIMEOUT_EN
    b_rs = n_rs;
    b_rd = n_rd;
    bus.mc_add = 6'h11;
    pins(0, 1, 0);
    tick(20);
    pins(1, 1, 1);
    tick(6);
    check("to_flag", timeout, 1);
    check("to_pairs", {n_rs - b_rs, n_rd - b_rd}, {32'd1, 32'd0});
    pins(0, 1, 0);
    tick(3);
    pins(1, 1, 1);
    tick(6);
    check("to_after_pairs", {n_rs - b_rs, n_rd - b_rd}, {32'd2, 32'd1});
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mc_bus_if.md
Name: mc_bus_if

Overview:
- Front end of the MCU parallel memory-controller bus.
- Synchronizes the active-low mc_ce/mc_we/mc_oe strobes and tracks bus cycles with a small FSM.
- Emits exactly one single-clock write strobe per completed write, carrying latched address and data, and one pulse each at the start and end of every read.
- Directly feeds the input-FIFO shift, output-FIFO pop and register-file ports. This replaces the ad-hoc level-following strobes in the top level.

Parameters:
- DATA_WIDTH, 16, width of mc_din / wr_data.
- ADD_WIDTH, 6, width of mc_add / wr_add / rd_add.
- SETTLE_CYCLES, 2, consecutive synced-WE-low clocks required before mc_din is sampled; range 1..15.
- TIMEOUT_CYCLES, 255, maximum clocks a cycle may stay active; used only with MC_BUS_TIMEOUT_EN.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mc_ce  in  1  raw chip enable, active low, asynchronous
- mc_we  in  1  raw write enable, active low, asynchronous
- mc_oe  in  1  raw output enable, active low, asynchronous
- mc_add  in  ADD_WIDTH  raw address
- mc_din  in  DATA_WIDTH  raw data from the pad input
- wr_stb  out  1  one-clock pulse: write completed
- wr_add  out  ADD_WIDTH  latched write address, valid while wr_stb is high and held until the next write
- wr_data  out  DATA_WIDTH  latched write data, same validity as wr_add
- rd_start  out  1  one-clock pulse at read-cycle entry (register-mux load)
- rd_done  out  1  one-clock pulse at read-cycle end (FIFO pop)
- rd_add  out  ADD_WIDTH  latched read address, held until the next read
- busy  out  1  FSM not in IDLE
- err_conflict  out  1  sticky: WE and OE were seen low together
- glitch_cnt  out  8  saturating count of write cycles aborted before the settle point

Behaviour:
- Synchronizers:
  - ce/we/oe each pass through 2 flops; all FSM decisions use the synced values.
  - mc_add and mc_din are sampled unsynchronized only at the latch points defined below.
- Reset values:
  - All outputs 0; FSM in IDLE; settle counter 0.
  - Synchronizer flops reset to 1 (bus idle).
- States: IDLE, WR, WR_HELD, RD, CONFLICT.
- IDLE:
  - ce_s=0, we_s=0, oe_s=1 -> WR; clear settle counter.
  - ce_s=0, oe_s=0, we_s=1 -> RD; latch rd_add; rd_start=1 on the following clock.
  - ce_s=0, we_s=0, oe_s=0 -> CONFLICT; set err_conflict.
- WR:
  - Settle counter increments each clock while we_s=0 and ce_s=0.
  - When the count reaches SETTLE_CYCLES: latch wr_add <= mc_add and wr_data <= mc_din, then -> WR_HELD.
  - If we_s or ce_s returns high first: glitch_cnt += 1 (saturates at 255), no wr_stb, -> IDLE.
- WR_HELD:
  - When we_s=1 or ce_s=1: wr_stb=1 for exactly one clock, -> IDLE.
  - Latency: wr_stb is asserted 1 clock after the synced edge, i.e. 3 clocks after the raw edge.
- RD:
  - When oe_s=1 or ce_s=1: rd_done=1 for one clock, -> IDLE.
  - rd_start and rd_done are never high in the same clock. A 1-clock read yields rd_start, then rd_done on the next clock.
- Conflict:
  - oe_s=0 and we_s=0 together while in WR, WR_HELD or RD -> CONFLICT, set err_conflict, no strobes.
  - CONFLICT -> IDLE only once ce_s, we_s and oe_s are all 1.
  - err_conflict clears only on reset.
- Back-to-back cycles: a new cycle can be entered on the clock after returning to IDLE. No minimum idle gap beyond 1 clock.
- Reset mid-cycle: FSM -> IDLE, no strobe is emitted. A cycle still active after reset is ignored until its strobes go high; then normal operation resumes.
- All outputs are registered.

Optional Feature:
- Macro MC_BUS_TIMEOUT_EN.
- When defined:
  - Adds output timeout (1 bit, sticky, reset 0) and a cycle counter sized for TIMEOUT_CYCLES.
  - The counter clears on IDLE exit and increments every clock in WR, WR_HELD and RD.
  - On reaching TIMEOUT_CYCLES: set timeout, suppress any wr_stb/rd_done for that cycle, -> CONFLICT, which waits for the bus to go idle.
- When undefined: no counter, no timeout port, and cycles may last indefinitely.

Test Plan:
- Write 0xA55A to address 0x19 with WE low for 6 clocks -> exactly one wr_stb, wr_add=0x19, wr_data=0xA55A, 3 clocks after the raw WE rise; busy low the next clock.
- WE low for only 1 clock (SETTLE_CYCLES=2) -> no wr_stb; glitch_cnt 0->1. Repeat 300 times -> glitch_cnt holds at 255.
- Read at address 0x00 with OE low for 5 clocks -> rd_start once with rd_add=0x00, rd_done once after the OE rise, never in the same clock. Two reads separated by 1 idle clock -> two rd_start/rd_done pairs.
- Drive WE and OE low together -> err_conflict=1, no strobes. Release to idle, then a normal write -> wr_stb fires and err_conflict stays 1 until reset.
- Assert reset during WR_HELD -> no wr_stb, all outputs 0. Release WE after reset -> no strobe. The next full write behaves normally.
- With MC_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=10, hold OE low for 20 clocks -> rd_start once, timeout=1, no rd_done. After release, a new read produces rd_start and rd_done.
